// File: rtl/ulpi_reg_access.sv
// ulpi_reg_access: ULPI PHY register read/write engine with abort retry and timeouts.
// Define ULPI_EXT_ADDR_EN to build the extended (8-bit) register address phase.
module ulpi_reg_access #(
  parameter int TIMEOUT   = 63,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_ULPI,
  input  logic       rst,
  input  logic       PrR,
  input  logic       PrW,
  input  logic [7:0] ADDR,
  input  logic [7:0] WR_VAL,
  output logic [7:0] REG_VAL,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] DATA_I,
  output logic [7:0] DATA_O,
  output logic       DATA_OE,
  output logic       STP
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE,
    CMD,
`ifdef ULPI_EXT_ADDR_EN
    EXT,
`endif
    WDATA,
    WSTP,
    RTURN,
    RDATA,
    RTURN2,
    WAITBUS
  } state_t;

  state_t        state, state_d, after_addr;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wval_q, wval_d;
  logic          wr_q, wr_d;
  logic [RW-1:0] retry, retry_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [7:0]    reg_d, dout_d;
  logic [5:0]    cmd_addr;
  logic          done_d, err_d, busy_d, oe_d, stp_d;
  logic          tmo, abort, fail;

`ifdef ULPI_EXT_ADDR_EN
  logic ext_q, ext_d;
`else
  logic unused_hi;
  assign unused_hi = ^addr_q[7:6];
`endif

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    wval_d  = wval_q;
    wr_d    = wr_q;
    retry_d = retry;
    reg_d   = REG_VAL;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;
    fail    = 1'b0;
    tmo     = (tcnt == T_MAX);
`ifdef ULPI_EXT_ADDR_EN
    ext_d   = ext_q;
    after_addr = ext_q ? EXT : (wr_q ? WDATA : RTURN);
`else
    after_addr = wr_q ? WDATA : RTURN;
`endif

    unique case (state)
      IDLE: begin
        if (!DIR && (PrR || PrW)) begin
          state_d = CMD;
          addr_d  = ADDR;
          wval_d  = WR_VAL;
          wr_d    = PrW;
          retry_d = '0;
`ifdef ULPI_EXT_ADDR_EN
          ext_d   = (ADDR >= 8'h2F);
`endif
        end
      end
      CMD: begin
        if (DIR)      abort   = 1'b1;
        else if (NXT) state_d = after_addr;
        else if (tmo) fail    = 1'b1;
      end
`ifdef ULPI_EXT_ADDR_EN
      EXT: begin
        if (DIR)      abort   = 1'b1;
        else if (NXT) state_d = wr_q ? WDATA : RTURN;
        else if (tmo) fail    = 1'b1;
      end
`endif
      WDATA: begin
        if (DIR)      abort   = 1'b1;
        else if (NXT) state_d = WSTP;
        else if (tmo) fail    = 1'b1;
      end
      WSTP: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      RTURN: begin
        if (DIR)      state_d = RDATA;
        else if (tmo) fail    = 1'b1;
      end
      RDATA: begin
        reg_d   = DATA_I;
        state_d = RTURN2;
      end
      RTURN2: begin
        if (!DIR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      WAITBUS: begin
        if (!DIR)     state_d = CMD;
        else if (tmo) fail    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // PHY grabbed the bus mid-command: back off and retry unless exhausted
    if (abort) begin
      if (retry == R_MAX) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = WAITBUS;
        retry_d = retry + 1'b1;
      end
    end
    if (fail) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    if (state_d != state) tcnt_d = '0;
    else if (tmo)         tcnt_d = tcnt;
    else                  tcnt_d = tcnt + 1'b1;

`ifdef ULPI_EXT_ADDR_EN
    cmd_addr = ext_d ? 6'h2F : addr_d[5:0];
`else
    cmd_addr = addr_d[5:0];
`endif

    // outputs are decoded from the next state so they leave the flops aligned
    busy_d = (state_d != IDLE);
    oe_d   = 1'b0;
    stp_d  = 1'b0;
    dout_d = '0;
    unique case (state_d)
      CMD: begin
        oe_d   = 1'b1;
        dout_d = {wr_d ? 2'b10 : 2'b11, cmd_addr};
      end
`ifdef ULPI_EXT_ADDR_EN
      EXT: begin
        oe_d   = 1'b1;
        dout_d = addr_d;
      end
`endif
      WDATA: begin
        oe_d   = 1'b1;
        dout_d = wval_d;
      end
      WSTP: begin
        oe_d  = 1'b1;
        stp_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wval_q  <= '0;
      wr_q    <= 1'b0;
      retry   <= '0;
      tcnt    <= '0;
      REG_VAL <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      DATA_O  <= '0;
      DATA_OE <= 1'b0;
      STP     <= 1'b0;
`ifdef ULPI_EXT_ADDR_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      wr_q    <= wr_d;
      retry   <= retry_d;
      tcnt    <= tcnt_d;
      REG_VAL <= reg_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      DATA_O  <= dout_d;
      DATA_OE <= oe_d;
      STP     <= stp_d;
`ifdef ULPI_EXT_ADDR_EN
      ext_q   <= ext_d;
`endif
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// tb_ulpi_reg_access: directed table plus randomized transactions against a
// transaction-level model of the ULPI register access engine and a scripted PHY.
module tb_ulpi_reg_access;

  localparam int TIMEOUT   = 63;
  localparam int MAX_RETRY = 3;
`ifdef ULPI_EXT_ADDR_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pr_r = 1'b0;
  logic       pr_w = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wr_val = '0;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic [7:0] data_i = '0;
  logic [7:0] reg_val;
  logic       busy, done, err;
  logic [7:0] data_o;
  logic       data_oe, stp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model_reg = '0;

  typedef struct {
    bit         wr;
    bit         both;
    logic [7:0] a;
    logic [7:0] v;
    logic [7:0] rd;
    int         wt;
    int         ab;
    logic [7:0] tx;
    bit         e;
  } vec_t;

  ulpi_reg_access #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_ULPI(clk),
    .rst(rst_n),
    .PrR(pr_r),
    .PrW(pr_w),
    .ADDR(addr),
    .WR_VAL(wr_val),
    .REG_VAL(reg_val),
    .busy(busy),
    .done(done),
    .err(err),
    .DIR(dir),
    .NXT(nxt),
    .DATA_I(data_i),
    .DATA_O(data_o),
    .DATA_OE(data_oe),
    .STP(stp)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One register transaction with a scripted PHY; expectations come from
  // the transaction rules (byte list, pulses, cycle budget), not the DUT.
  task automatic run_txn(input string tag, input bit wr, input bit both,
                         input logic [7:0] a, input logic [7:0] v,
                         input logic [7:0] rd, input int wt, input int ab,
                         output logic [7:0] tx_seen, output bit err_seen);
    logic [7:0] acc[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx, tx_first;
    bit eff_wr, ext, exp_err, fin, have_tx, oe_bad, stp_bad, ok;
    bit end_busy, end_oe;
    int n_done, n_err, n_stp, n_busy, exp_busy;
    int phase, wait_n, hold, ab_left;

    eff_wr = wr || both;
    ext = EXT_EN && (a >= 8'h2F);
    tx = {eff_wr ? 2'b10 : 2'b11, ext ? 6'h2F : a[5:0]};
    exp_err = (ab > MAX_RETRY) || (wt > TIMEOUT);
    if (!exp_err) begin
      exp_q.push_back(tx);
      if (ext) exp_q.push_back(a);
      if (eff_wr) exp_q.push_back(v);
    end
    if (ab > MAX_RETRY)   exp_busy = MAX_RETRY * 4 + 1;
    else if (wt > TIMEOUT) exp_busy = TIMEOUT + 1;
    else exp_busy = ab * 4 + exp_q.size() * (wt + 1) + (eff_wr ? 1 : 3);
    if (!eff_wr && !exp_err) model_reg = rd;

    fin = 0; have_tx = 0; oe_bad = 0; stp_bad = 0;
    end_busy = 1; end_oe = 1; tx_first = '0;
    n_done = 0; n_err = 0; n_stp = 0; n_busy = 0;
    phase = 0; wait_n = 0; hold = 0; ab_left = ab;

    pr_w = eff_wr;
    pr_r = !wr || both;
    addr = a;
    wr_val = v;
    dir = 1'b0;
    nxt = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      tick();
      if (c == 0) begin
        pr_r = 1'b0;
        pr_w = 1'b0;
        addr = 8'($urandom);
        wr_val = 8'($urandom);
      end
      if (busy) n_busy++;
      if (done) n_done++;
      if (err) n_err++;
      if (stp) begin
        n_stp++;
        if (data_o !== 8'h00 || data_oe !== 1'b1) stp_bad = 1;
      end
      if (data_oe && !have_tx) begin
        tx_first = data_o;
        have_tx = 1;
      end
      if (done || err) begin
        fin = 1;
        end_busy = busy;
        end_oe = data_oe;
      end else begin
        nxt = 1'b0;
        if (phase == 3) begin
          if (data_oe) phase = 0;
          else begin
            dir = 1'b1;
            phase = 4;
          end
        end else if (phase == 4) begin
          dir = 1'b1;
          data_i = rd;
          phase = 5;
        end else if (phase == 5) begin
          dir = 1'b0;
          data_i = 8'($urandom);
          phase = 6;
        end else if (phase == 1) begin
          if (data_oe) oe_bad = 1;
          if (hold > 0) hold--;
          else begin
            dir = 1'b0;
            phase = 0;
          end
        end
        if (phase == 0 && data_oe && !stp) begin
          if (ab_left > 0) begin
            dir = 1'b1;
            hold = 2;
            ab_left--;
            phase = 1;
          end else if (wait_n < wt) begin
            wait_n++;
          end else begin
            nxt = 1'b1;
            wait_n = 0;
            acc.push_back(data_o);
            if (!eff_wr) phase = 3;
          end
        end
      end
    end
    nxt = 1'b0;
    dir = 1'b0;
    data_i = '0;

    tx_seen = tx_first;
    err_seen = (n_err != 0);
    chk($sformatf("%s complete", tag), 32'(fin), 32'd1);
    chk($sformatf("%s txcmd", tag), 32'(tx_first), 32'(tx));
    ok = (acc.size() == exp_q.size());
    if (ok) foreach (acc[i]) if (acc[i] !== exp_q[i]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s bytes: got %p, expected %p", tag, acc, exp_q);
    end
    chk($sformatf("%s done", tag), 32'(n_done), exp_err ? 32'd0 : 32'd1);
    chk($sformatf("%s err", tag), 32'(n_err), exp_err ? 32'd1 : 32'd0);
    chk($sformatf("%s stp", tag), 32'(n_stp), (eff_wr && !exp_err) ? 32'd1 : 32'd0);
    chk($sformatf("%s stp shape", tag), 32'(stp_bad), 32'd0);
    chk($sformatf("%s reg_val", tag), 32'(reg_val), 32'(model_reg));
    chk($sformatf("%s end idle", tag), 32'({end_busy, end_oe}), 32'd0);
    if (ab > 0) chk($sformatf("%s abort release", tag), 32'(oe_bad), 32'd0);
    n_tests++;
    if (wt > TIMEOUT && ab <= MAX_RETRY) begin
      if (n_busy < TIMEOUT || n_busy > TIMEOUT + 1) begin
        n_fail++;
        $display("FAIL %s busy cycles: got %0d, expected %0d..%0d", tag, n_busy, TIMEOUT,
                 TIMEOUT + 1);
      end
    end else if (n_busy != exp_busy) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d, expected %0d", tag, n_busy, exp_busy);
    end
    tick();
    chk($sformatf("%s single pulse", tag), 32'({done, err}), 32'd0);
  endtask

  initial begin
    vec_t tv[$];
    logic [7:0] txs;
    bit es;

    tv.push_back('{1'b0, 1'b0, 8'h16, 8'h00, 8'hBA, 0, 0, 8'hD6, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'h04, 8'h45, 8'h00, 0, 0, 8'h84, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'h1F, 8'h00, 8'h5C, 0, 1, 8'hDF, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'h1F, 8'h00, 8'hE1, 0, 4, 8'hDF, 1'b1});
    tv.push_back('{1'b1, 1'b0, 8'h0A, 8'h33, 8'h00, 1, 3, 8'h8A, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'h04, 8'h66, 8'h00, 1000, 0, 8'h84, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'h2E, 8'h00, 8'h77, TIMEOUT - 1, 0, 8'hEE, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h05, 8'h99, 8'h00, 0, 0, 8'h85, 1'b0});
`ifdef ULPI_EXT_ADDR_EN
    tv.push_back('{1'b1, 1'b1, 8'h90, 8'h21, 8'h00, 0, 0, 8'hAF, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'h2F, 8'h00, 8'h4B, 2, 0, 8'hEF, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'h80, 8'h00, 8'h3C, 0, 0, 8'hEF, 1'b0});
`else
    tv.push_back('{1'b1, 1'b0, 8'hC4, 8'h12, 8'h00, 0, 0, 8'h84, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 1, 0, 8'hFF, 1'b0});
`endif

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset outputs", 32'({data_o, data_oe, stp, busy, done, err, reg_val}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    dir = 1'b1;
    pr_r = 1'b1;
    addr = 8'h01;
    repeat (3) tick();
    chk("dir blocks request", 32'({busy, data_oe}), 32'd0);
    pr_r = 1'b0;
    dir = 1'b0;
    tick();
    chk("no late accept", 32'(busy), 32'd0);

    foreach (tv[i]) begin
      run_txn($sformatf("vec%0d", i), tv[i].wr, tv[i].both, tv[i].a, tv[i].v,
              tv[i].rd, tv[i].wt, tv[i].ab, txs, es);
      chk($sformatf("vec%0d table tx", i), 32'(txs), 32'(tv[i].tx));
      chk($sformatf("vec%0d table err", i), 32'(es), 32'(tv[i].e));
    end

    pr_r = 1'b1;
    addr = 8'h16;
    tick();
    pr_r = 1'b0;
    nxt = 1'b1;
    chk("rst seq txcmd", 32'({data_oe, data_o}), 32'h1D6);
    tick();
    nxt = 1'b0;
    dir = 1'b1;
    tick();
    data_i = 8'h11;
    chk("rst seq turnaround", 32'({busy, data_oe}), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mid read", 32'({data_o, data_oe, stp, busy, done, err, reg_val}), 32'd0);
    model_reg = '0;
    dir = 1'b0;
    data_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle after reset", 32'({busy, reg_val}), 32'd0);
    run_txn("read after reset", 1'b0, 1'b0, 8'h16, 8'h00, 8'h6D, 0, 0, txs, es);

    for (int k = 0; k < 40; k++) begin
      run_txn($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), txs, es);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
